// File: rtl/alu_dispatch.sv
// alu_dispatch: RV32I integer decode into a one-hot ALU control word plus
// operands, buffered by a 2-entry skid buffer (valid/ready on both sides).
// in_ready and out_valid come straight from registers.
// Optional: define DISPATCH_CNT_EN to build the dispatched-op counter;
// otherwise dispatch_cnt is tied to zero.
module alu_dispatch #(
    parameter int OP_W = 12
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [31:0]     in_pc,
    input  logic [31:0]     in_rs1_data,
    input  logic [31:0]     in_rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] alu_op,
    output logic [31:0]     alu_src1,
    output logic [31:0]     alu_src2,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic            illegal,
    output logic [31:0]     dispatch_cnt
);
    // Fixed alu_op bit positions
    localparam int B_ADD = 0, B_SUB = 1, B_SLT = 2, B_SLTU = 3, B_AND = 4;
    localparam int B_OR  = 6, B_XOR = 7, B_SLL = 8, B_SRL = 9, B_SRA = 10, B_LUI = 11;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [31:0]     src1;
        logic [31:0]     src2;
        logic [4:0]      rd;
        logic            rd_we;
        logic            illegal;
    } ent_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t      r_state;
    ent_t        r_head;
    ent_t        r_skid;
    logic        r_out_valid;
    logic        r_in_ready;
    ent_t        w_dec;
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_f7_zero;
    logic        w_f7_alt;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_u;
    logic [31:0] w_shamt;
    logic        w_in_fire;
    logic        w_out_fire;

    assign w_opc     = in_inst[6:0];
    assign w_f3      = in_inst[14:12];
    assign w_f7      = in_inst[31:25];
    assign w_f7_zero = (w_f7 == 7'b0000000);
    assign w_f7_alt  = (w_f7 == 7'b0100000);
    assign w_imm_i   = {{20{in_inst[31]}}, in_inst[31:20]};
    assign w_imm_u   = {in_inst[31:12], 12'b0};
    assign w_shamt   = {27'b0, in_inst[24:20]};

    // Decode the incoming instruction; an encoding is legal iff it selects an op bit
    always_comb begin
        w_dec      = '0;
        w_dec.rd   = in_inst[11:7];
        unique case (w_opc)
            7'b0110111: begin                          // LUI
                w_dec.op[B_LUI] = 1'b1;
                w_dec.src2      = w_imm_u;
            end
            7'b0010111: begin                          // AUIPC
                w_dec.op[B_ADD] = 1'b1;
                w_dec.src1      = in_pc;
                w_dec.src2      = w_imm_u;
            end
            7'b1101111, 7'b1100111: begin              // JAL / JALR: link address
                w_dec.op[B_ADD] = (w_opc == 7'b1101111) || (w_f3 == 3'b000);
                w_dec.src1      = in_pc;
                w_dec.src2      = 32'd4;
            end
            7'b0010011: begin                          // OP-IMM
                w_dec.src1 = in_rs1_data;
                w_dec.src2 = w_imm_i;
                case (w_f3)
                    3'b000: w_dec.op[B_ADD]  = 1'b1;
                    3'b010: w_dec.op[B_SLT]  = 1'b1;
                    3'b011: w_dec.op[B_SLTU] = 1'b1;
                    3'b100: w_dec.op[B_XOR]  = 1'b1;
                    3'b110: w_dec.op[B_OR]   = 1'b1;
                    3'b111: w_dec.op[B_AND]  = 1'b1;
                    3'b001: begin
                        w_dec.src2      = w_shamt;
                        w_dec.op[B_SLL] = w_f7_zero;
                    end
                    default: begin                     // 3'b101
                        w_dec.src2      = w_shamt;
                        w_dec.op[B_SRL] = w_f7_zero;
                        w_dec.op[B_SRA] = w_f7_alt;
                    end
                endcase
            end
            7'b0110011: begin                          // OP
                w_dec.src1 = in_rs1_data;
                w_dec.src2 = in_rs2_data;
                case (w_f3)
                    3'b000: begin
                        w_dec.op[B_ADD] = w_f7_zero;
                        w_dec.op[B_SUB] = w_f7_alt;
                    end
                    3'b001: w_dec.op[B_SLL]  = w_f7_zero;
                    3'b010: w_dec.op[B_SLT]  = w_f7_zero;
                    3'b011: w_dec.op[B_SLTU] = w_f7_zero;
                    3'b100: w_dec.op[B_XOR]  = w_f7_zero;
                    3'b110: w_dec.op[B_OR]   = w_f7_zero;
                    3'b111: w_dec.op[B_AND]  = w_f7_zero;
                    default: begin                     // 3'b101
                        w_dec.op[B_SRL] = w_f7_zero;
                        w_dec.op[B_SRA] = w_f7_alt;
                    end
                endcase
            end
            default: ;
        endcase
        w_dec.illegal = ~|w_dec.op;
        w_dec.rd_we   = ~w_dec.illegal && (w_dec.rd != 5'd0);
    end

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // Skid-buffer FSM; flush empties it but leaves the head fields untouched
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_head      <= '0;
            r_skid      <= '0;
        end else if (flush) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                EMPTY: if (w_in_fire) begin
                    r_head      <= w_dec;
                    r_state     <= ONE;
                    r_out_valid <= 1'b1;
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_head <= w_dec;
                    end else if (w_in_fire) begin
                        r_skid     <= w_dec;
                        r_state    <= FULL;
                        r_in_ready <= 1'b0;
                    end else if (w_out_fire) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                FULL: if (w_out_fire) begin
                    r_head     <= r_skid;
                    r_state    <= ONE;
                    r_in_ready <= 1'b1;
                end
                default: begin
                    r_state     <= EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign alu_op    = r_head.op;
    assign alu_src1  = r_head.src1;
    assign alu_src2  = r_head.src2;
    assign rd        = r_head.rd;
    assign rd_we     = r_head.rd_we;
    assign illegal   = r_head.illegal;

`ifdef DISPATCH_CNT_EN
    logic [31:0] r_cnt;

    // Count ops handed to execute; wraps naturally, cleared only by reset
    always_ff @(posedge clk) begin
        if (!resetn)
            r_cnt <= '0;
        else if (w_out_fire && !flush)
            r_cnt <= r_cnt + 32'd1;
    end

    assign dispatch_cnt = r_cnt;
`else
    assign dispatch_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: directed vectors for alu_dispatch, checked against a
// FIFO-level behavioural model every cycle plus hand-computed literals.
module tb_alu_dispatch;
    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, out_ready;
    logic        in_ready, out_valid, rd_we, illegal;
    logic [31:0] in_inst, in_pc, in_rs1_data, in_rs2_data;
    logic [11:0] alu_op;
    logic [31:0] alu_src1, alu_src2, dispatch_cnt;
    logic [4:0]  rd;

    alu_dispatch #(.OP_W(12)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .rd(rd), .rd_we(rd_we), .illegal(illegal), .dispatch_cnt(dispatch_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [11:0] op;
        logic [31:0] s1, s2;
        logic [4:0]  rd;
        logic        we, ill;
    } ment_t;

    ment_t       q[$];
    logic [31:0] m_cnt = 0;
    logic [31:0] obs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model decode: choose the op by mnemonic (bit index), then operands
    function automatic ment_t mdec(input logic [31:0] inst, pc, a, b);
        ment_t e;
        int    idx = -1;
        int    rtab[8];
        int    itab[8];
        logic [6:0] f7;
        logic [2:0] f3;
        rtab = '{0, 8, 2, 3, 7, 9, 6, 4};
        itab = '{0, -1, 2, 3, 7, -1, 6, 4};
        f7 = inst[31:25];
        f3 = inst[14:12];
        e.s1 = 0; e.s2 = 0;
        case (inst[6:0])
            7'h37: begin idx = 11; e.s2 = inst & 32'hFFFFF000; end
            7'h17: begin idx = 0; e.s1 = pc; e.s2 = inst & 32'hFFFFF000; end
            7'h6F: begin idx = 0; e.s1 = pc; e.s2 = 4; end
            7'h67: begin if (f3 == 0) idx = 0; e.s1 = pc; e.s2 = 4; end
            7'h13: begin
                e.s1 = a;
                e.s2 = $signed(inst) >>> 20;
                if (f3 == 1 || f3 == 5) begin
                    e.s2 = (inst >> 20) & 32'h1F;
                    if (f7 == 0) idx = (f3 == 1) ? 8 : 9;
                    else if (f7 == 7'h20 && f3 == 5) idx = 10;
                end else idx = itab[f3];
            end
            7'h33: begin
                e.s1 = a; e.s2 = b;
                if (f7 == 0) idx = rtab[f3];
                else if (f7 == 7'h20 && f3 == 0) idx = 1;
                else if (f7 == 7'h20 && f3 == 5) idx = 10;
            end
            default: idx = -1;
        endcase
        e.ill = (idx < 0);
        e.op  = e.ill ? 12'h000 : 12'(1 << idx);
        e.rd  = inst[11:7];
        e.we  = !e.ill && (e.rd != 0);
        return e;
    endfunction

    // Model state: FIFO of depth 2, updated on the clock from sampled inputs
    always @(posedge clk) begin
        automatic bit m_in  = in_valid && (q.size() < 2);
        automatic bit m_out = (q.size() > 0) && out_ready;
        if (!resetn) begin
            q.delete();
            m_cnt = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (m_out) begin
                void'(q.pop_front());
                m_cnt = m_cnt + 1;
            end
            if (m_in) q.push_back(mdec(in_inst, in_pc, in_rs1_data, in_rs2_data));
        end
    end

    // Compare DUT against the model away from the active edge
    always @(negedge clk) begin
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) begin
            chk("alu_op", alu_op, q[0].op);
            chk("illegal", illegal, q[0].ill);
            chk("rd_we", rd_we, q[0].we);
            if (!q[0].ill) begin
                chk("alu_src1", alu_src1, q[0].s1);
                chk("alu_src2", alu_src2, q[0].s2);
                chk("rd", rd, q[0].rd);
            end
            if (out_ready && !flush) obs.push_back(alu_src2);
        end
`ifdef DISPATCH_CNT_EN
        chk("dispatch_cnt", dispatch_cnt, m_cnt);
`else
        chk("dispatch_cnt", dispatch_cnt, 0);
`endif
    end

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rdn,
                                        input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rdn, opc};
    endfunction

    // Called at posedge+1; holds the entry until accepted, then drops in_valid
    task automatic send(input logic [31:0] inst, pc, a, b);
        int k = 0;
        in_valid = 1; in_inst = inst; in_pc = pc; in_rs1_data = a; in_rs2_data = b;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk("send_timeout", 1, 0);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] f7;
        resetn = 0; flush = 0; in_valid = 0; out_ready = 1;
        in_inst = 0; in_pc = 0; in_rs1_data = 0; in_rs2_data = 0;
        idle(2);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_src1", alu_src1, 0);
        chk("rst_src2", alu_src2, 0);
        chk("rst_rd_rdwe_ill", {rd, rd_we, illegal}, 0);
        chk("rst_cnt", dispatch_cnt, 0);
        resetn = 1;
        idle(1);

        // 1: ADDI x1,x0,5
        send(32'h00500093, 32'h0, 32'h0, 32'h0);
        chk("addi_op", alu_op, 12'h001);
        chk("addi_src", {alu_src1, alu_src2}, 32'd5);
        chk("addi_rd", {rd, rd_we, illegal}, {5'd1, 1'b1, 1'b0});

        // 2: SUB then SRAI back-to-back
        send(32'h402081B3, 32'h0, 32'd10, 32'd3);
        chk("sub_op", alu_op, 12'h002);
        chk("sub_src1", alu_src1, 32'd10);
        chk("sub_src2", alu_src2, 32'd3);
        send(32'h40335313, 32'h0, 32'd77, 32'd0);
        chk("srai_op", alu_op, 12'h400);
        chk("srai_src2", alu_src2, 32'd3);

        // 3: LUI, JAL
        send(32'h123452B7, 32'h0, 32'h0, 32'h0);
        chk("lui_op", alu_op, 12'h800);
        chk("lui_src2", alu_src2, 32'h12345000);
        send(32'h008000EF, 32'h80000000, 32'h0, 32'h0);
        chk("jal_op", alu_op, 12'h001);
        chk("jal_src1", alu_src1, 32'h80000000);
        chk("jal_src2", alu_src2, 32'd4);
        idle(3);

        // 4: backpressure with three ADDIs
        out_ready = 0;
        obs.delete();
        fork
            begin
                send(32'h00100093, 0, 0, 0);
                send(32'h00200093, 0, 0, 0);
                send(32'h00300093, 0, 0, 0);
            end
            begin
                repeat (4) @(negedge clk);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_head", alu_src2, 1);
                @(posedge clk); #1;
                out_ready = 1;
            end
        join
        idle(4);
        chk("bp_count", obs.size(), 3);
        if (obs.size() == 3) begin
            chk("bp_order0", obs[0], 1);
            chk("bp_order1", obs[1], 2);
            chk("bp_order2", obs[2], 3);
        end

        // 5: flush while FULL with a simultaneous input
        out_ready = 0;
        send(32'h00100093, 0, 0, 0);
        send(32'h00200093, 0, 0, 0);
        chk("fl_full", in_ready, 0);
        in_valid = 1; in_inst = 32'h00700093; flush = 1;
        idle(1);
        flush = 0; in_valid = 0;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        chk("fl_hold_src2", alu_src2, 1);
        out_ready = 1;
        idle(2);
        chk("fl_dropped", out_valid, 0);

        // 6: illegal all-ones word
        send(32'hFFFFFFFF, 0, 32'h1234, 32'h5678);
        chk("ill_flag", illegal, 1);
        chk("ill_op", alu_op, 0);
        chk("ill_rdwe", rd_we, 0);
        idle(2);

        // Sweep OP / OP-IMM across funct3 and both funct7 variants, plus misc
        for (int j = 0; j < 2; j++) begin
            f7 = (j == 0) ? 7'h00 : 7'h20;
            for (int f = 0; f < 8; f++) begin
                send(enc(f7, 5'(f + 1), 5'd2, 3'(f), 5'(f), 7'h33), 0, $urandom, $urandom);
                send(enc(f7, 5'(f + 1), 5'd2, 3'(f), 5'(f + 8), 7'h13), 0, $urandom, 0);
            end
        end
        send(32'hFFF10093, 0, 32'd9, 0);                 // ADDI x1,x2,-1
        send(32'h00001017, 32'h100, 0, 0);               // AUIPC x0
        send(32'h000080E7, 32'h200, 0, 0);               // JALR x1
        send(32'h00002083, 0, 0, 0);                     // LW: illegal
        idle(3);

        // Counter: reset mid-run, then five dispatches
        resetn = 0;
        idle(2);
        resetn = 1;
        for (int i = 0; i < 5; i++) send(32'h00100093, 0, 0, 0);
        idle(3);
`ifdef DISPATCH_CNT_EN
        chk("cnt_five", dispatch_cnt, 5);
`else
        chk("cnt_off", dispatch_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1);
    end
endmodule
